subtractor_serial: RTL and testbench



---
 rtl/subtractor_serial.sv | 106 ++++++++++
 tb/tb_subtractor_serial.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/subtractor_serial.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, WIDTH shift cycles per result.
// Define SUBTRACTOR_SERIAL_OVERFLOW_EN to add the registered signed Overflow output.
module subtractor_serial #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Minuend,
    input  logic [WIDTH-1:0] Subtrahend,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Difference,
    output logic             Borrow_out
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] work;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             a;
    logic             b;
    logic             d;
    logic             br_next;
    logic             last;
    logic [WIDTH-1:0] shifted;

    // Single full-subtractor cell on the current LSBs.
    assign a       = a_sr[0];
    assign b       = b_sr[0];
    assign d       = a ^ b ^ br;
    assign br_next = (~a & b) | (~(a ^ b) & br);
    assign last    = (cnt == CW'(WIDTH - 1));
    // Working result is one bit short; the newest bit completes it on the last edge.
    assign shifted = {d, work};

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            work       <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Difference <= '0;
            Borrow_out <= 1'b0;
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
            Overflow   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        a_sr  <= Minuend;
                        b_sr  <= Subtrahend;
                        work  <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_next;
                    work <= shifted[WIDTH-1:1];
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        state      <= DONE;
                        Busy       <= 1'b0;
                        Done       <= 1'b1;
                        Difference <= shifted;
                        Borrow_out <= br_next;
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
                        // On the last edge a/b are the latched operand MSBs and d is the result MSB.
                        Overflow   <= (a != b) && (d != a);
`endif
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subtractor_serial.sv
// Bench for subtractor_serial (WIDTH=8): arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_subtractor_serial;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         Start = 1'b0;
    logic [W-1:0] Minuend = '0;
    logic [W-1:0] Subtrahend = '0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Difference;
    logic         Borrow_out;
    logic         ovf_obs;

    subtractor_serial #(.WIDTH(W)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .Minuend    (Minuend),
        .Subtrahend (Subtrahend),
        .Busy       (Busy),
        .Done       (Done),
        .Difference (Difference),
        .Borrow_out (Borrow_out)
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
        ,
        .Overflow   (ovf_obs)
`endif
    );

`ifndef SUBTRACTOR_SERIAL_OVERFLOW_EN
    assign ovf_obs = 1'b0;
`endif

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge Clk) cyc++;

    // Reference model: phase 0 idle, 1..W busy, W+1 done; results from plain arithmetic.
    int           k = 0;
    logic [W-1:0] la = '0, lb = '0;
    logic [W-1:0] m_diff = '0;
    logic         m_bo = 1'b0;
    logic         m_ovf = 1'b0;

    always @(posedge Clk) begin
        if (!Reset_n) begin
            k = 0; m_diff = '0; m_bo = 1'b0; m_ovf = 1'b0;
        end else if (k == 0) begin
            if (Start) begin
                k = 1; la = Minuend; lb = Subtrahend;
            end
        end else if (k == W) begin
            m_diff = la - lb;
            m_bo   = (la < lb);
            m_ovf  = (la[W-1] != lb[W-1]) && (m_diff[W-1] != la[W-1]);
            k = W + 1;
        end else if (k == W + 1) begin
            k = 0;
        end else begin
            k++;
        end
    end

    always @(negedge Clk) begin
        if (cyc > 0) begin
            check("busy", 32'(Busy), 32'(k >= 1 && k <= W));
            check("done", 32'(Done), 32'(k == W + 1));
            check("difference", 32'(Difference), 32'(m_diff));
            check("borrow_out", 32'(Borrow_out), 32'(m_bo));
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
            check("overflow", 32'(ovf_obs), 32'(m_ovf));
`endif
        end
    end

    // Log of completions for the directed checks.
    logic [W-1:0] diff_q[$];
    logic         bo_q[$];
    logic         ovf_q[$];
    int           done_cyc_q[$];
    int           busy_cnt = 0;

    always @(negedge Clk) begin
        if (Done === 1'b1) begin
            diff_q.push_back(Difference);
            bo_q.push_back(Borrow_out);
            ovf_q.push_back(ovf_obs);
            done_cyc_q.push_back(cyc);
        end
        if (Busy === 1'b1) busy_cnt++;
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic wait_done(input int n0, input string name);
        int t;
        t = 0;
        while (done_cyc_q.size() == n0 && t < 40) begin
            tick();
            t++;
        end
        if (done_cyc_q.size() == n0) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    // Launch one op; returns acceptance cycle, completion index, and busy cycles seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name,
                          output int acc, output int idx, output int busyc);
        int n0, b0;
        n0 = done_cyc_q.size();
        b0 = busy_cnt;
        Start = 1'b1; Minuend = a; Subtrahend = b;
        tick();
        acc = cyc;
        Start = 1'b0; Minuend = 8'hA5; Subtrahend = 8'h5A;
        wait_done(n0, name);
        tick(); tick();
        idx = n0;
        busyc = busy_cnt - b0;
    endtask

    initial begin
        int acc, idx, busyc, n0;

        tick(); tick();
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_diff", 32'(Difference), 32'd0);
        check("rst_bo", 32'(Borrow_out), 32'd0);
        Reset_n = 1'b1;
        tick();

        // 5 - 3: Done visible in the 9th cycle counting E0's cycle as 1.
        run_op(8'h05, 8'h03, "op1", acc, idx, busyc);
        if (done_cyc_q.size() > idx) begin
            check("op1_latency", 32'(done_cyc_q[idx] - acc + 1), 32'd9);
            check("op1_diff", 32'(diff_q[idx]), 32'h02);
            check("op1_bo", 32'(bo_q[idx]), 32'd0);
        end
        check("op1_busy_cycles", 32'(busyc), 32'd8);

        run_op(8'h03, 8'h05, "op2", acc, idx, busyc);
        if (done_cyc_q.size() > idx) begin
            check("op2_diff", 32'(diff_q[idx]), 32'hFE);
            check("op2_bo", 32'(bo_q[idx]), 32'd1);
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
            check("op2_ovf", 32'(ovf_q[idx]), 32'd0);
`endif
        end

        run_op(8'h80, 8'h01, "op3", acc, idx, busyc);
        if (done_cyc_q.size() > idx) begin
            check("op3_diff", 32'(diff_q[idx]), 32'h7F);
            check("op3_bo", 32'(bo_q[idx]), 32'd0);
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
            check("op3_ovf", 32'(ovf_q[idx]), 32'd1);
`endif
        end

        // Start pulsed during the 3rd SHIFT cycle must be dropped.
        n0 = done_cyc_q.size();
        Start = 1'b1; Minuend = 8'h20; Subtrahend = 8'h10;
        tick();
        Start = 1'b0;
        tick(); tick();
        Start = 1'b1; Minuend = 8'h10; Subtrahend = 8'h01;
        tick();
        Start = 1'b0;
        wait_done(n0, "op4");
        repeat (15) tick();
        check("op4_done_count", 32'(done_cyc_q.size() - n0), 32'd1);
        if (done_cyc_q.size() > n0) check("op4_diff", 32'(diff_q[n0]), 32'h10);

        // Reset in the 4th SHIFT cycle aborts the op silently.
        n0 = done_cyc_q.size();
        Start = 1'b1; Minuend = 8'hFF; Subtrahend = 8'h01;
        tick();
        Start = 1'b0;
        tick(); tick(); tick();
        Reset_n = 1'b0;
        tick();
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_diff", 32'(Difference), 32'd0);
        check("abort_bo", 32'(Borrow_out), 32'd0);
        // Reset and Start on the same edge: reset wins.
        Start = 1'b1;
        tick();
        check("rst_wins_busy", 32'(Busy), 32'd0);
        Start = 1'b0;
        Reset_n = 1'b1;
        repeat (15) tick();
        check("abort_no_done", 32'(done_cyc_q.size() - n0), 32'd0);

        run_op(8'hFF, 8'hFF, "op5", acc, idx, busyc);
        if (done_cyc_q.size() > idx) begin
            check("op5_diff", 32'(diff_q[idx]), 32'h00);
            check("op5_bo", 32'(bo_q[idx]), 32'd0);
        end

        // Start held 30 cycles: accepts at 1, 11, 21 -> three Dones, 10 cycles apart.
        n0 = done_cyc_q.size();
        Start = 1'b1; Minuend = 8'h00; Subtrahend = 8'h01;
        repeat (30) tick();
        Start = 1'b0;
        repeat (12) tick();
        check("b2b_done_count", 32'(done_cyc_q.size() - n0), 32'd3);
        for (int i = n0; i < done_cyc_q.size(); i++) begin
            check("b2b_diff", 32'(diff_q[i]), 32'hFF);
            check("b2b_bo", 32'(bo_q[i]), 32'd1);
            if (i > n0) check("b2b_spacing", 32'(done_cyc_q[i] - done_cyc_q[i-1]), 32'd10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
